seg_scan_ctrl: RTL and testbench

Time-multiplexed scan controller for a multi-digit common-segment 7-segment display. Holds a NUM_DIGITS-nibble display value loaded over a valid/ready handshake. Drives the existing seg7 hex decoder one digit at a time, with a blanking dead-time between digits to suppress ghosting. Sits between the counter/value logic and the uo_out/uio_out pad mapping.

---
 rtl/seg_pkg.sv | 13 +
 rtl/seg7.sv | 32 +++
 rtl/seg_scan_ctrl.sv | 156 +++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package seg_pkg;

    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned NIBBLE_W       = 4;
    localparam int unsigned SEG_W          = 7;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/seg7.sv
// Hex nibble to 7-segment decoder; seg_c[0]=a .. seg_c[6]=g, 1 = lit.
module seg7
    import seg_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    seg_c
);

    always_comb begin
        seg_c = '0;
        unique case (nibble)
            4'h0: seg_c = 7'h3F;
            4'h1: seg_c = 7'h06;
            4'h2: seg_c = 7'h5B;
            4'h3: seg_c = 7'h4F;
            4'h4: seg_c = 7'h66;
            4'h5: seg_c = 7'h6D;
            4'h6: seg_c = 7'h7D;
            4'h7: seg_c = 7'h07;
            4'h8: seg_c = 7'h7F;
            4'h9: seg_c = 7'h6F;
            4'hA: seg_c = 7'h77;
            4'hB: seg_c = 7'h7C;
            4'hC: seg_c = 7'h39;
            4'hD: seg_c = 7'h5E;
            4'hE: seg_c = 7'h79;
            4'hF: seg_c = 7'h71;
            default: seg_c = '0;
        endcase
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed digit scanner with blanking dead-time, shadowed value load
// committed only at frame wrap, and optional leading-zero suppression.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned SCAN_CYCLES  = 10000,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           en,
    input  logic                           lz_en,
    input  logic                           load_valid,
    output logic                           load_ready,
    input  logic [NIBBLE_W*NUM_DIGITS-1:0] load_data,
    output logic [SEG_W-1:0]               seg_out,
    output logic [NUM_DIGITS-1:0]          dig_en,
    output logic                           frame_start
);

    localparam int unsigned DATA_W = NIBBLE_W * NUM_DIGITS;
    localparam int unsigned IDX_W  = $clog2(NUM_DIGITS);
    localparam int unsigned CNT_W  = $clog2(SCAN_CYCLES);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_CYCLES - BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    scan_state_e            state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DATA_W-1:0]      active_q, active_d;
    logic [DATA_W-1:0]      pending_q, pending_d;
    logic                   pend_vld_q, pend_vld_d;
    logic [SEG_W-1:0]       seg_d;
    logic [NUM_DIGITS-1:0]  dig_d;
    logic                   frame_d;

    logic [NIBBLE_W-1:0]    cur_nibble_c;
    logic [SEG_W-1:0]       cur_seg_c;
    logic [NUM_DIGITS-1:0]  upper_zero_c;
    logic                   zero_run_c;
    logic                   suppress_c;

    assign cur_nibble_c = active_q[32'(idx_q) * NIBBLE_W +: NIBBLE_W];

    seg7 u_seg7 (
        .nibble (cur_nibble_c),
        .seg_c  (cur_seg_c)
    );

    // upper_zero_c[i] set when nibbles i..NUM_DIGITS-1 are all zero
    always_comb begin
        upper_zero_c = '0;
        zero_run_c   = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            zero_run_c      = zero_run_c & (active_q[i*NIBBLE_W +: NIBBLE_W] == '0);
            upper_zero_c[i] = zero_run_c;
        end
    end

    assign suppress_c = lz_en && (idx_q != '0) && upper_zero_c[idx_q];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        active_d   = active_q;
        pending_d  = pending_q;
        pend_vld_d = pend_vld_q;
        seg_d      = seg_out;
        dig_d      = dig_en;
        frame_d    = 1'b0;

        if (!en) begin
            state_d = BLANK;
            cnt_d   = '0;
            idx_d   = '0;
            seg_d   = '0;
            dig_d   = '0;
            if (pend_vld_q) begin
                active_d   = pending_q;
                pend_vld_d = 1'b0;
            end
        end else begin
            unique case (state_q)
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        cnt_d   = '0;
                        state_d = SHOW;
                        dig_d   = NUM_DIGITS'(1) << idx_q;
                        seg_d   = suppress_c ? '0 : cur_seg_c;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    if (cnt_q == SHOW_LAST) begin
                        cnt_d   = '0;
                        state_d = BLANK;
                        dig_d   = '0;
                        seg_d   = '0;
                        if (idx_q == IDX_LAST) begin
                            // frame wrap: only point where a shadowed value goes live
                            idx_d   = '0;
                            frame_d = 1'b1;
                            if (pend_vld_q) begin
                                active_d   = pending_q;
                                pend_vld_d = 1'b0;
                            end
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = BLANK;
            endcase
        end

        // capture uses the pre-edge ready, so it never collides with a commit
        if (load_valid && load_ready) begin
            pending_d  = load_data;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BLANK;
            cnt_q       <= '0;
            idx_q       <= '0;
            active_q    <= '0;
            pending_q   <= '0;
            pend_vld_q  <= 1'b0;
            load_ready  <= 1'b1;
            seg_out     <= '0;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            active_q    <= active_d;
            pending_q   <= pending_d;
            pend_vld_q  <= pend_vld_d;
            load_ready  <= !pend_vld_d;
            seg_out     <= seg_d;
            dig_en      <= dig_d;
            frame_start <= frame_d;
        end
    end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl against a frame-position reference model.
`timescale 1ns/1ps
module tb_seg_scan_ctrl;

    localparam int ND    = 4;
    localparam int SC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = ND * SC;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        lz_en = 1'b0;
    logic        load_valid = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready;
    logic [6:0]  seg_out;
    logic [3:0]  dig_en;
    logic        frame_start;

    int checks = 0;
    int errors = 0;

    // reference model: position in frame counted in enabled edges since park
    int          m_pos = 0;
    logic        m_pv = 1'b0;
    logic [15:0] m_active = '0;
    logic [15:0] m_pending = '0;

    logic [12:0] act;
    logic [12:0] exp_v;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_CYCLES  (SC),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .lz_en       (lz_en),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_data   (load_data),
        .seg_out     (seg_out),
        .dig_en      (dig_en),
        .frame_start (frame_start)
    );

    function automatic logic [6:0] seg7_ref(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    function automatic void model_edge();
        logic cap;
        if (rst) begin
            m_pos = 0; m_pv = 1'b0; m_active = '0; m_pending = '0;
            return;
        end
        cap = load_valid && !m_pv;
        if (!en) begin
            m_pos = 0;
            if (m_pv) begin m_active = m_pending; m_pv = 1'b0; end
        end else begin
            m_pos++;
            if ((m_pos % FRAME == 0) && m_pv) begin m_active = m_pending; m_pv = 1'b0; end
        end
        if (cap) begin m_pending = load_data; m_pv = 1'b1; end
    endfunction

    // expected {frame_start, load_ready, dig_en, seg_out}
    function automatic logic [12:0] expect_vec();
        int p, d;
        logic lit;
        logic [3:0] dig;
        logic [6:0] seg;
        p   = m_pos % FRAME;
        d   = p / SC;
        lit = (p % SC) >= BC;
        dig = lit ? 4'(1 << d) : 4'b0;
        seg = lit ? seg7_ref(4'(m_active >> (4 * d))) : 7'b0;
        if (lz_en && d > 0 && (m_active >> (4 * d)) == 16'h0) seg = 7'b0;
        return {(p == 0) && (m_pos > 0), !m_pv, dig, seg};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        act   = {frame_start, load_ready, dig_en, seg_out};
        exp_v = expect_vec();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({frame_start, load_ready, dig_en, seg_out} !== {1'b0, 1'b1, 4'b0, 7'b0}) begin
            errors++;
            $display("FAIL reset_vals got %h expected %h", {frame_start, load_ready, dig_en, seg_out}, 13'h0800);
        end
        tick();
        model_edge();
        #2 rst = 1'b0;
    endtask

    task automatic test_scan_timing(input string tag);
        en = 1'b1;
        for (int c = 0; c < FRAME + 8; c++) begin
            tick();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL %s cyc%0d got %h expected %h", tag, c + 1, act, exp_v);
            end
            if (c + 1 == 2) begin
                checks++;
                if (dig_en !== 4'b0001 || seg_out !== 7'h3F) begin
                    errors++;
                    $display("FAIL %s_first_lit got %b/%h expected 0001/3f", tag, dig_en, seg_out);
                end
            end
        end
    endtask

    task automatic test_load_commit();
        // park and restart so the frame position is known
        en = 1'b0; tick(); en = 1'b1;
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            load_valid = (c == 5);
            load_data  = (c == 5) ? 16'h4321 : 16'($urandom);
            tick();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL load_commit cyc%0d got %h expected %h", c + 1, act, exp_v);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_wrap_load();
        int guard = 0;
        while (!(m_pos % FRAME == FRAME - 1 && !m_pv) && guard < 4 * FRAME) begin
            tick(); guard++;
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL wrap_seek got %h expected %h", act, exp_v);
            end
        end
        checks++;
        if (guard >= 4 * FRAME) begin
            errors++;
            $display("FAIL wrap_seek_timeout got %0d expected <%0d", guard, 4 * FRAME);
        end
        for (int c = 0; c < 2 * FRAME + 4; c++) begin
            load_valid = (c == 0) || (c > 3 && c < 20);
            load_data  = (c == 0) ? 16'h00A5 : 16'($urandom);
            tick();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL wrap_load cyc%0d got %h expected %h", c, act, exp_v);
            end
        end
        load_valid = 1'b0;
    endtask

    task automatic test_lz(input logic [15:0] val);
        en = 1'b0; lz_en = 1'b1;
        load_valid = 1'b1; load_data = val;
        tick();
        load_valid = 1'b0;
        tick();
        en = 1'b1;
        for (int c = 0; c < FRAME + 2; c++) begin
            tick();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL lz_%h cyc%0d got %h expected %h", val, c, act, exp_v);
            end
        end
    endtask

    task automatic test_en_drop();
        en = 1'b0; lz_en = 1'b0;
        tick(); tick();
        en = 1'b1;
        tick(); tick();
        load_valid = 1'b1; load_data = 16'hBEEF;
        tick();
        load_valid = 1'b0;
        for (int c = 0; c < FRAME && (m_pos % FRAME) != 2 * SC + 4; c++) tick();
        en = 1'b0;
        tick();
        checks++;
        if (act !== 13'h0800 || act !== exp_v) begin
            errors++;
            $display("FAIL en_drop_park got %h expected %h", act, 13'h0800);
        end
        en = 1'b1;
        tick();
        checks++;
        if (dig_en !== 4'b0000 || seg_out !== 7'h00) begin
            errors++;
            $display("FAIL en_drop_dark got %b/%h expected 0000/00", dig_en, seg_out);
        end
        tick();
        checks++;
        if (dig_en !== 4'b0001 || seg_out !== 7'h71 || frame_start !== 1'b0) begin
            errors++;
            $display("FAIL en_drop_resume got %b/%h/%b expected 0001/71/0", dig_en, seg_out, frame_start);
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < 4; c++) tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({frame_start, load_ready, dig_en, seg_out} !== 13'h0800) begin
            errors++;
            $display("FAIL async_reset got %h expected %h", {frame_start, load_ready, dig_en, seg_out}, 13'h0800);
        end
        en = 1'b1;
        tick();
        #2 rst = 1'b0;
        test_scan_timing("post_reset");
    endtask

    task automatic test_random();
        for (int c = 0; c < 1500; c++) begin
            load_valid = ($urandom_range(0, 3) == 0);
            load_data  = 16'($urandom);
            if ($urandom_range(0, 1) == 0) load_data = load_data & 16'h00F0;
            if (en) en = ($urandom_range(0, 299) != 0);
            else    en = ($urandom_range(0, 3) == 0);
            if (!en) lz_en = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL random cyc%0d got %h expected %h", c, act, exp_v);
            end
        end
        load_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_scan_timing("scan");
        test_load_commit();
        test_wrap_load();
        test_lz(16'h0005);
        test_lz(16'h0105);
        test_en_drop();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
